// File: rtl/muli_elastic_pkg.sv
// muli_elastic_pkg: shared multiplier constants and the extend/multiply/select helper.
//   MULI_MAX_LATENCY : deepest legal pipeline
//   mul_select       : w-bit operands (in the low bits of 64-bit args) -> selected w-bit product half
package muli_elastic_pkg;

    localparam int MULI_MAX_LATENCY = 8;

    function automatic logic [63:0] mul_select(
        input logic [63:0] a,
        input logic [63:0] b,
        input int          w,
        input logic        sgn,
        input logic        high
    );
        logic [127:0] mask, ea, eb, p;
        mask = (128'd1 << w) - 128'd1;
        ea = {64'd0, a} & mask;
        eb = {64'd0, b} & mask;
        if (sgn && a[6'(w - 1)]) ea = ea | ~mask;
        if (sgn && b[6'(w - 1)]) eb = eb | ~mask;
        // Keep only the 2w-bit product so the high slice has no stray upper bits.
        p = (ea * eb) & ((128'd1 << (2 * w)) - 128'd1);
        return high ? 64'(p >> w) : 64'(p & mask);
    endfunction

endpackage

// File: rtl/muli_elastic_pipe_stage.sv
// elastic_pipe_stage: one elastic register slice with its own valid bit.
//   up_valid/d   : upstream valid and data
//   down_ready   : ready of the next slice (or consumer)
//   ready        : this slice can load (empty or draining)
//   valid/q      : registered valid and data
module elastic_pipe_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    input  logic [W-1:0] d,
    input  logic         down_ready,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] q
);

    // An empty slice always loads, which is what lets bubbles collapse under back-pressure.
    assign ready = !valid || down_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (ready) begin
            valid <= up_valid;
            q     <= d;
        end
    end

endmodule

// File: rtl/muli_elastic.sv
// muli_elastic: elastic-handshake integer multiplier with per-stage valid bits.
//   clk, rst (async, active-low)
//   lhs/lhs_valid/lhs_ready, rhs/rhs_valid/rhs_ready : joined operand channels
//   result/result_valid/result_ready                   : product channel
module muli_elastic
    import muli_elastic_pkg::*;
#(
    parameter int DATA_TYPE = 32,
    parameter int LATENCY   = 4,
    parameter int SIGNED    = 0,
    parameter int HIGH_HALF = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    input  logic                 result_ready,
    output logic [DATA_TYPE-1:0] result,
    output logic                 result_valid,
    output logic                 lhs_ready,
    output logic                 rhs_ready
);

    if (LATENCY < 1 || LATENCY > MULI_MAX_LATENCY) begin : g_bad_latency
        $error("muli_elastic: LATENCY must be 1..%0d", MULI_MAX_LATENCY);
    end
    if (DATA_TYPE < 2 || DATA_TYPE > 64) begin : g_bad_width
        $error("muli_elastic: DATA_TYPE must be 2..64");
    end

    // v[0] is the joined input valid; rdy[LATENCY+1] is the consumer.
    logic [LATENCY:0]   v;
    logic [LATENCY+1:1] rdy;

    assign v[0]             = lhs_valid && rhs_valid;
    assign rdy[LATENCY + 1] = result_ready;
    assign lhs_ready        = rdy[1] && rhs_valid;
    assign rhs_ready        = rdy[1] && lhs_valid;
    assign result_valid     = v[LATENCY];

    if (LATENCY == 1) begin : g_l1
        elastic_pipe_stage #(.W(DATA_TYPE)) u_s1 (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (v[0]),
            .d          (DATA_TYPE'(mul_select(64'(lhs), 64'(rhs), DATA_TYPE, 1'(SIGNED), 1'(HIGH_HALF)))),
            .down_ready (rdy[2]),
            .ready      (rdy[1]),
            .valid      (v[1]),
            .q          (result)
        );
    end else begin : g_ln
        logic [2*DATA_TYPE-1:0] ops;
        logic [DATA_TYPE-1:0]   dq [2:LATENCY];

        // Operands are registered first so the multiplier sees a full cycle.
        elastic_pipe_stage #(.W(2 * DATA_TYPE)) u_s1 (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (v[0]),
            .d          ({lhs, rhs}),
            .down_ready (rdy[2]),
            .ready      (rdy[1]),
            .valid      (v[1]),
            .q          (ops)
        );

        elastic_pipe_stage #(.W(DATA_TYPE)) u_s2 (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (v[1]),
            .d          (DATA_TYPE'(mul_select(64'(ops[2*DATA_TYPE-1:DATA_TYPE]), 64'(ops[DATA_TYPE-1:0]),
                                               DATA_TYPE, 1'(SIGNED), 1'(HIGH_HALF)))),
            .down_ready (rdy[3]),
            .ready      (rdy[2]),
            .valid      (v[2]),
            .q          (dq[2])
        );

        for (genvar k = 3; k <= LATENCY; k++) begin : g_delay
            elastic_pipe_stage #(.W(DATA_TYPE)) u_s (
                .clk        (clk),
                .rst        (rst),
                .up_valid   (v[k-1]),
                .d          (dq[k-1]),
                .down_ready (rdy[k+1]),
                .ready      (rdy[k]),
                .valid      (v[k]),
                .q          (dq[k])
            );
        end

        assign result = dq[LATENCY];
    end

endmodule
